m92_bus_decoder: RTL

Registered CPU bus decoder for the M92 main CPU, the sequential successor to the combinational address translator. Decodes each CPU access into a one-hot peripheral select or an SDRAM ROM fetch. Owns the ROM bank register and runs the SDRAM request/acknowledge handshake. Sits between the V33 bus interface and the SDRAM/peripheral fabric, and generates CPU wait states, a read-timeout fallback and an optional one-entry ROM fetch cache.

---
 rtl/m92_bus_decoder.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/m92_bus_decoder.sv
// rtl/m92_bus_decoder.sv - registered M92 CPU bus decoder with SDRAM ROM fetch handshake
// Define M92_BUS_DECODER_CACHE_EN to build the one-entry ROM fetch cache.
module m92_bus_decoder #(
  parameter int DW = 16,
  parameter int BANK_W = 4,
  parameter int SDR_AW = 25,
  parameter logic [SDR_AW-1:0] ROM_BASE = '0,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [19:0]       cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  output logic              cpu_ready,
  output logic [DW-1:0]     cpu_din,
  input  logic              bank_wr,
  input  logic [BANK_W-1:0] bank_din,
  input  logic [BANK_W-1:0] bank_mask,
  input  logic              alt_map,
  output logic [6:0]        sel,
  input  logic [DW-1:0]     periph_din,
  output logic              sdr_req,
  output logic [SDR_AW-1:0] sdr_addr,
  input  logic              sdr_ack,
  input  logic [DW-1:0]     sdr_data,
  output logic              timeout_err
);
  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_PERIPH, S_SDR_WAIT, S_DONE} state_t;

  localparam logic [6:0] SEL_ROM = 7'b0000001;
  localparam logic [6:0] SEL_PF  = 7'b0000010;
  localparam logic [6:0] SEL_RAM = 7'b0000100;
  localparam logic [6:0] SEL_BUF = 7'b0001000;
  localparam logic [6:0] SEL_SPR = 7'b0010000;
  localparam logic [6:0] SEL_VID = 7'b0100000;
  localparam logic [6:0] SEL_EEP = 7'b1000000;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [SDR_AW-21:0] ROM_HI = ROM_BASE[SDR_AW-1:20];

  state_t              state_q, state_d;
  logic [19:0]         addr_q, addr_d;
  logic                wr_q, wr_d;
  logic                release_q, release_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                cpu_ready_q, cpu_ready_d;
  logic [DW-1:0]       cpu_din_q, cpu_din_d;
  logic [6:0]          sel_q, sel_d;
  logic                sdr_req_q, sdr_req_d;
  logic [SDR_AW-1:0]   sdr_addr_q, sdr_addr_d;
  logic                timeout_err_q, timeout_err_d;

  logic [6:0]          dec_sel;
  logic [SDR_AW-1:0]   rom_addr;
  logic [BANK_W-1:0]   eff_bank;
  logic                cache_hit;
  logic [DW-1:0]       cache_rdata;

  assign eff_bank = (bank_q & bank_mask) | (addr_q[19:16] & ~bank_mask);

  always_comb begin
    dec_sel  = '0;
    rom_addr = {ROM_HI, addr_q};
    if (addr_q[19:16] == 4'hC) begin
      dec_sel = SEL_ROM;
    end else if (addr_q[19:16] == 4'hD) begin
      dec_sel = SEL_PF;
    end else if (addr_q[19:16] == 4'hE) begin
      dec_sel = SEL_RAM;
    end else if (addr_q[19:16] == 4'hF) begin
      if (addr_q[15:14] == 2'b00)         dec_sel = SEL_EEP;
      else if (addr_q[15:12] == 4'h8)     dec_sel = SEL_BUF;
      else if (addr_q[15:4] == 12'h900)   dec_sel = SEL_SPR;
      else if (addr_q[15:1] == 15'h4C00)  dec_sel = SEL_VID;
      else if (addr_q[15:4] == 12'hFFF) begin
        // Reset vector page mirrors the top of ROM bank 7.
        dec_sel  = SEL_ROM;
        rom_addr = {ROM_HI, 16'h7FFF, addr_q[3:0]};
      end
    end else if (alt_map && addr_q[19:16] == 4'h8) begin
      dec_sel = SEL_PF;
    end else begin
      dec_sel  = SEL_ROM;
      rom_addr = {ROM_HI, (addr_q[19:17] == 3'b101) ? eff_bank : addr_q[19:16], addr_q[15:0]};
    end
  end

`ifdef M92_BUS_DECODER_CACHE_EN
  logic              cache_valid_q, cache_valid_d;
  logic [SDR_AW-1:0] cache_tag_q, cache_tag_d;
  logic [DW-1:0]     cache_data_q, cache_data_d;

  always_comb begin
    cache_valid_d = cache_valid_q;
    cache_tag_d   = cache_tag_q;
    cache_data_d  = cache_data_q;
    if (state_q == S_SDR_WAIT && sdr_ack) begin
      cache_valid_d = 1'b1;
      cache_tag_d   = sdr_addr_q;
      cache_data_d  = sdr_data;
    end
    if (bank_wr) cache_valid_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
    end else begin
      cache_valid_q <= cache_valid_d;
      cache_tag_q   <= cache_tag_d;
      cache_data_q  <= cache_data_d;
    end
  end

  assign cache_hit   = cache_valid_q && (cache_tag_q == rom_addr);
  assign cache_rdata = cache_data_q;
`else
  assign cache_hit   = 1'b0;
  assign cache_rdata = '0;
`endif

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wr_d          = wr_q;
    release_d     = release_q;
    cnt_d         = cnt_q;
    bank_d        = bank_wr ? bank_din : bank_q;
    cpu_ready_d   = 1'b0;
    cpu_din_d     = cpu_din_q;
    sel_d         = sel_q;
    sdr_req_d     = sdr_req_q;
    sdr_addr_d    = sdr_addr_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      S_IDLE: begin
        if (!cpu_rd && !cpu_wr) begin
          release_d = 1'b0;
        end else if (!release_q) begin
          addr_d  = cpu_addr;
          wr_d    = cpu_wr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        sel_d = dec_sel;
        if (dec_sel != SEL_ROM) begin
          state_d = S_PERIPH;
        end else if (wr_q) begin
          state_d = S_DONE;
        end else if (cache_hit) begin
          cpu_din_d = cache_rdata;
          state_d   = S_DONE;
        end else begin
          sdr_req_d  = 1'b1;
          sdr_addr_d = rom_addr;
          cnt_d      = '0;
          state_d    = S_SDR_WAIT;
        end
      end
      S_PERIPH: begin
        if (!wr_q) cpu_din_d = (sel_q == '0) ? '1 : periph_din;
        state_d = S_DONE;
      end
      S_SDR_WAIT: begin
        // Ack is checked first so a same-cycle ack beats the timeout.
        if (sdr_ack) begin
          cpu_din_d = sdr_data;
          sdr_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q >= TO_LAST) begin
          cpu_din_d     = '1;
          sdr_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end else begin
          cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        cpu_ready_d = 1'b1;
        sel_d       = '0;
        release_d   = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      release_q     <= 1'b0;
      cnt_q         <= '0;
      bank_q        <= '0;
      cpu_ready_q   <= 1'b0;
      cpu_din_q     <= '0;
      sel_q         <= '0;
      sdr_req_q     <= 1'b0;
      sdr_addr_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wr_q          <= wr_d;
      release_q     <= release_d;
      cnt_q         <= cnt_d;
      bank_q        <= bank_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_din_q     <= cpu_din_d;
      sel_q         <= sel_d;
      sdr_req_q     <= sdr_req_d;
      sdr_addr_q    <= sdr_addr_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cpu_ready   = cpu_ready_q;
  assign cpu_din     = cpu_din_q;
  assign sel         = sel_q;
  assign sdr_req     = sdr_req_q;
  assign sdr_addr    = sdr_addr_q;
  assign timeout_err = timeout_err_q;
endmodule
